// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, registered borrow.
// Ports: clk, rst (sync, active-high), in_valid/in_ready + a/b/bin in,
//        out_valid/out_ready + diff/bout out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             d;
  logic             bo;
  logic [WIDTH:0]   r_cat;
  logic [WIDTH-1:0] r_nxt;
  logic             last;

  always_comb begin
    x     = a_sr[0];
    y     = b_sr[0];
    d     = x ^ y ^ borrow;
    bo    = (~x & y) | (~(x ^ y) & borrow);
    // new bit enters at the MSB; concat keeps WIDTH=1 legal
    r_cat = {d, r_sr};
    r_nxt = r_cat[WIDTH:1];
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow   <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_nxt;
          borrow <= bo;
          cnt    <= cnt + CW'(1);
          if (last) begin
            diff      <= r_nxt;
            bout      <= bo;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Expected values are hand-computed constants.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       bin1;
  logic       out_valid1;
  logic [0:0] diff1;
  logic       bout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1),
    .out_valid(out_valid1), .out_ready(1'b1),
    .diff(diff1), .bout(bout1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // accept, then WIDTH edges later the result must be valid
  task automatic run_op(input string tag,
                        input logic [7:0] va,
                        input logic [7:0] vb,
                        input logic vbin,
                        input logic [7:0] ed,
                        input logic eb,
                        input bit inject);
    a        = va;
    b        = vb;
    bin      = vbin;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    a        = 8'hAA;
    b        = 8'h55;
    chk({tag, "_acc_rdy"}, in_ready, 0);
    for (int k = 1; k < 8; k++) begin
      cyc();
      in_valid = 1'b0;
      chk({tag, "_sh_vld"}, out_valid, 0);
      chk({tag, "_sh_rdy"}, in_ready, 0);
      if (inject && k == 2) in_valid = 1'b1;
    end
    cyc();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    cyc();
    chk({tag, "_idle_rdy"}, in_ready, 1);
    chk({tag, "_idle_vld"}, out_valid, 0);
  endtask

  logic [1:0] tbl [8];

  initial begin
    tbl = '{2'b00, 2'b11, 2'b11, 2'b01,
            2'b10, 2'b00, 2'b00, 2'b11};
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    in_valid1 = 1'b0;
    a1        = '0;
    b1        = '0;
    bin1      = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_rdy1", in_ready1, 1);

    run_op("t05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    handoff("t05_03");
    run_op("t00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    handoff("t00_01");
    run_op("t10_0f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    handoff("t10_0f");
    run_op("t00_ff", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
    handoff("t00_ff");
    run_op("tff_00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
    handoff("tff_00");

    // backpressure with stray in_valid pulses in SHIFT and DONE
    out_ready = 1'b0;
    run_op("bp", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 1);
      a        = 8'h33;
      b        = 8'h11;
      cyc();
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_rdy", in_ready, 0);
      chk("bp_hold_diff", diff, 8'h7F);
      chk("bp_hold_bout", bout, 0);
    end
    in_valid = 1'b0;
    handoff("bp");
    chk("bp_keep_diff", diff, 8'h7F);
    cyc();
    chk("bp_stay_idle", in_ready, 1);

    // reset after third shift edge
    a        = 8'h55;
    b        = 8'h11;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_vld", out_valid, 0);
    chk("mrst_diff", diff, 0);
    chk("mrst_bout", bout, 0);
    cyc();
    chk("mrst_no_out", out_valid, 0);
    run_op("t3c_0a", 8'h3C, 8'h0A, 1'b0, 8'h32, 1'b0, 1'b0);
    handoff("t3c_0a");

    // exhaustive WIDTH=1
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v         = 3'(i);
      a1        = v[2];
      b1        = v[1];
      bin1      = v[0];
      in_valid1 = 1'b1;
      cyc();
      in_valid1 = 1'b0;
      chk("w1_acc_vld", out_valid1, 0);
      chk("w1_acc_rdy", in_ready1, 0);
      cyc();
      chk("w1_vld", out_valid1, 1);
      chk($sformatf("w1_diff_%0d", i), diff1, tbl[i][1]);
      chk($sformatf("w1_bout_%0d", i), bout1, tbl[i][0]);
      cyc();
      chk("w1_idle", in_ready1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor built around a single full-subtractor cell, with a registered borrow fed back each cycle. It accepts two operands and a borrow-in over a valid/ready handshake. It shifts the operands LSB-first through the cell, one bit per clock. It returns the N-bit difference and final borrow-out over a second valid/ready handshake. It is the sequential consumer of the full-subtractor cell's diff/bout outputs and serves as the multi-bit stage in the arithmetic training-circuit set.

Parameters:
WIDTH, 8, operand and difference width in bits; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand set a/b/bin is valid
in_ready  output  1  block can accept operands (IDLE only)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in for bit 0
out_valid  output  1  diff/bout hold a completed result
out_ready  input  1  downstream accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow; 1 when a < b + bin (unsigned)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. rst sampled high on a rising edge forces state IDLE and clears all registers: in_ready=1, out_valid=0, diff=0, bout=0, bit counter=0, shift registers=0. rst has priority over every other input, including mid-SHIFT and mid-DONE; any in-flight operation is discarded with no output produced.
- State machine: three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at an edge: load a_sr<=a, b_sr<=b, borrow<=bin, count<=0, go to SHIFT.
  - diff/bout keep their previous values until overwritten.
- SHIFT:
  - in_ready=0, out_valid=0. in_valid is ignored and operands are not sampled.
  - Each cycle, with x=a_sr[0], y=b_sr[0], c=borrow:
    - d = x^y^c
    - bo = (~x&y) | (~(x^y)&c)
  - Shift registers shift right by 1.
  - d enters the result shift register at the MSB, so after WIDTH cycles bit 0 sits at the LSB.
  - borrow<=bo; count<=count+1.
  - When count==WIDTH-1, the same edge commits the last bit, copies the result to diff, sets bout<=bo, and moves to DONE.
- DONE:
  - out_valid=1. diff and bout stay stable while out_valid=1 and out_ready=0; the bench checks hold under backpressure.
  - On out_ready=1 at an edge: go to IDLE and drop out_valid. diff/bout keep their values.
  - in_ready is 0 in DONE. No new operand is accepted in the same cycle as result handoff.
- Latency:
  - Operand accept edge at cycle 0; out_valid=1 from cycle WIDTH onward, i.e. exactly WIDTH clocks after accept.
  - Minimum throughput is one operation per WIDTH+2 cycles (accept, WIDTH shifts, handoff).
- WIDTH=1: a single SHIFT cycle, then DONE. Result equals a direct full-subtractor evaluation.
- Counter width: clog2(WIDTH)+1 bits. The counter never wraps during an operation.
- Arithmetic: unsigned. diff={bout,diff} satisfies {bout,diff} = 2^WIDTH*bout + (a - b - bin) mod 2^WIDTH, with bout=1 iff a < b+bin.
- X-safety: with rst asserted, every output is known in the cycle after the edge regardless of other inputs.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, out_ready=1 -> out_valid exactly 8 cycles after accept, diff=0x02, bout=0; in_ready=0 throughout SHIFT/DONE.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1. Then a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
- Backpressure: after result a=0x80, b=0x01 (diff=0x7F, bout=0), hold out_ready=0 for 5 cycles -> out_valid stays 1 and diff/bout stay stable. A new in_valid pulse during SHIFT and DONE is ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst at SHIFT cycle 3 -> next cycle in_ready=1, out_valid=0, diff=0, bout=0. A fresh operation a=0x3C, b=0x0A afterwards yields diff=0x32, bout=0.
- Exhaustive at WIDTH=1: all 8 (a,b,bin) combinations -> (diff,bout) = 00,11,11,01,10,00,00,11 in order a,b,bin = 000..111.
